// File: rtl/disparity_search_ctrl_pkg.sv
// disp_pkg: shared widths, state encoding and cost ceiling for the disparity search blocks
package disp_pkg;
    localparam int COST_W = 18;
    localparam int DISP_W = 6;
    localparam logic [COST_W-1:0] COST_MAX = '1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/disparity_search_ctrl_if.sv
// disparity_search_ctrl_if: control, cost-unit request/return and result signals of the search controller
interface disparity_search_ctrl_if;
    import disp_pkg::*;
    logic start;
    logic [DISP_W-1:0] cfg_max_disp;
    logic busy;
    logic req_valid;
    logic [DISP_W-1:0] req_disp;
    logic req_ready;
    logic cost_valid;
    logic [COST_W-1:0] cost;
    logic [DISP_W-1:0] cost_disp;
    logic done;
    logic [COST_W-1:0] best_cost;
    logic [DISP_W-1:0] best_disp;
    logic err;
    modport master (
        input start, cfg_max_disp, req_ready, cost_valid, cost, cost_disp,
        output busy, req_valid, req_disp, done, best_cost, best_disp, err
    );
    modport slave (
        output start, cfg_max_disp, req_ready, cost_valid, cost, cost_disp,
        input busy, req_valid, req_disp, done, best_cost, best_disp, err
    );
endinterface

// File: rtl/disparity_search_ctrl_min_tracker.sv
// min_tracker: registered running minimum with strict-less update, so ties keep the earlier index
module min_tracker #(
    parameter int VAL_W = 18,
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic             upd,
    input  logic [VAL_W-1:0] val,
    input  logic [IDX_W-1:0] idx,
    output logic [VAL_W-1:0] min_val,
    output logic [IDX_W-1:0] min_idx
);
    always_ff @(posedge clk) begin
        if (rst || init) begin
            min_val <= '1;
            min_idx <= '0;
        end else if (upd && val < min_val) begin
            min_val <= val;
            min_idx <= idx;
        end
    end
endmodule

// File: rtl/disparity_search_ctrl.sv
// disparity_search_ctrl: issues disparities 0..max_disp to the cost unit and reports the lowest returned cost
module disparity_search_ctrl
    import disp_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 8
) (
    input logic clk,
    input logic rst,
    disparity_search_ctrl_if.master bus
);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    state_t state, nxt;
    logic [DISP_W:0] issue_cnt, ret_cnt;
    logic [OUT_W-1:0] outstanding;
    logic [DISP_W-1:0] max_disp;
    logic accept, issue, ret_ok, ret_last;
    always_comb begin
        accept = state == IDLE && bus.start;
        ret_ok = state == RUN && bus.cost_valid && outstanding != '0;
        ret_last = ret_ok && ret_cnt == {1'b0, max_disp};
        bus.req_valid = state == RUN && issue_cnt <= {1'b0, max_disp} && outstanding < OUT_W'(MAX_OUTSTANDING);
        issue = bus.req_valid && bus.req_ready;
        bus.req_disp = issue_cnt[DISP_W-1:0];
        bus.busy = state == RUN;
        bus.done = state == DONE;
        nxt = accept ? RUN : ret_last ? DONE : state == DONE ? IDLE : state;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            issue_cnt <= '0;
            ret_cnt <= '0;
            outstanding <= '0;
            max_disp <= '0;
            bus.err <= 1'b0;
        end else if (accept) begin
            state <= nxt;
            issue_cnt <= '0;
            ret_cnt <= '0;
            outstanding <= '0;
            max_disp <= bus.cfg_max_disp;
            bus.err <= 1'b0;
        end else begin
            state <= nxt;
            if (issue) issue_cnt <= issue_cnt + 1'b1;
            if (ret_ok) ret_cnt <= ret_cnt + 1'b1;
            if (issue != ret_ok) outstanding <= issue ? outstanding + 1'b1 : outstanding - 1'b1;
            if (bus.cost_valid && !ret_ok) bus.err <= 1'b1;
        end
    end
    min_tracker #(.VAL_W(COST_W), .IDX_W(DISP_W)) u_min (
        .clk(clk),
        .rst(rst),
        .init(accept),
        .upd(ret_ok),
        .val(bus.cost),
        .idx(bus.cost_disp),
        .min_val(bus.best_cost),
        .min_idx(bus.best_disp)
    );
endmodule

// File: doc/disparity_search_ctrl.md
Name: disparity_search_ctrl

Overview:
- Sequences the disparity search for one pixel in the stereo depth pipeline.
- On start, issues disparity indices 0..cfg_max_disp to the window-matching (cost) unit and collects the returned matching costs.
- Keeps a running minimum of cost and records the disparity that produced it.
- On completion, presents best_cost/best_disp to the depth-computation stage and pulses done.

Parameters:
- COST_W, 18, width of matching-cost values.
- DISP_W, 6, width of disparity index.
- MAX_OUTSTANDING, 8, maximum number of issued-but-unreturned cost requests.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  begin a search; sampled only in IDLE.
- cfg_max_disp  in  DISP_W  last disparity to evaluate (inclusive); latched on accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- req_valid  out  1  disparity request to the cost unit is valid.
- req_disp  out  DISP_W  disparity index requested.
- req_ready  in  1  cost unit accepts the request when req_valid && req_ready.
- cost_valid  in  1  a returned cost is valid this cycle.
- cost  in  COST_W  returned matching cost.
- cost_disp  in  DISP_W  disparity the returned cost belongs to.
- done  out  1  one-cycle pulse; the result is final.
- best_cost  out  COST_W  minimum cost of the last search; held until the next accepted start.
- best_disp  out  DISP_W  disparity of best_cost; held likewise.
- err  out  1  sticky; set on a protocol violation, cleared by rst or an accepted start.

Behaviour:
- Reset values:
  - state=IDLE.
  - busy=0, req_valid=0, req_disp=0, done=0, err=0.
  - best_cost = all-ones, best_disp=0.
  - Internal issue_cnt, ret_cnt and outstanding = 0.
- IDLE:
  - start=1 latches cfg_max_disp.
  - Loads best_cost = all-ones and best_disp = 0; clears counters and err.
  - Moves to RUN; busy=1 the next cycle.
- RUN, issue side:
  - req_valid=1 while issue_cnt <= max_disp and outstanding < MAX_OUTSTANDING.
  - req_disp = issue_cnt.
  - On handshake: issue_cnt++ and outstanding++.
  - req_disp holds stable while req_valid && !req_ready.
- RUN, return side:
  - On cost_valid: if cost < best_cost (strict), then best_cost<=cost and best_disp<=cost_disp.
  - Equal costs keep the earlier winner.
  - ret_cnt++ and outstanding-- on every return.
  - A simultaneous issue handshake and return leaves outstanding unchanged.
- Completion:
  - The cycle a return makes ret_cnt == max_disp+1, the state goes to DONE.
  - The final comparison is included in the result.
- DONE:
  - Lasts one cycle: done=1, busy=0.
  - Then returns to IDLE.
  - best_* are final in that cycle and are held.
- Latency: with req_ready=1 always and a fixed cost-unit latency L (L+1 ≤ MAX_OUTSTANDING), done occurs max_disp+L+3 cycles after the start cycle.
- Boundaries:
  - cfg_max_disp=0: exactly one request is issued.
  - cfg_max_disp = 2^DISP_W−1 (63): issue_cnt is DISP_W+1 bits wide so it does not wrap; 64 requests are issued.
  - start while not IDLE: ignored.
  - cost_valid in IDLE/DONE, or with outstanding==0: return ignored, err<=1.
  - rst mid-search: aborts immediately to reset values; the system must also flush the cost unit.
- The comparison is unsigned; the cost and disparity widths are never truncated.

Decomposition:
- Shared package disp_pkg:
  - COST_W and DISP_W constants.
  - state enum {IDLE, RUN, DONE}.
  - COST_MAX constant (all-ones).
- One natural sub-module: min_tracker, a registered running-min with strict-less update and load-init. It is shared with other window-search blocks.

Test Plan:
- Costs {50,30,30,40} for disp 0..3, max_disp=3, L=2, ready=1 -> done at cycle 8 after start, best_cost=30, best_disp=1 (tie keeps earlier).
- max_disp=0, cost=7 -> exactly one req (disp 0), best_cost=7, best_disp=0, done one pulse.
- max_disp=63, req_ready toggling 1/0, L=5 -> 64 requests, no repeats or skips, req_disp stable while stalled, minimum inserted at disp 63 is reported.
- MAX_OUTSTANDING=8, L=20 -> req_valid drops after 8 issues and resumes one cycle after the first return.
- cost_valid pulse while IDLE -> err=1, best_* unchanged; next start clears err.
- rst asserted mid-RUN -> next cycle busy=0, req_valid=0, best_cost=all-ones; a new start runs normally.
